// File: rtl/ddr_maint_pkg.sv
// Shared types for the DDR maintenance sequencer: channel FSM states and command codes.
package ddr_maint_pkg;
  localparam int MAX_CHAN = 4;

  typedef enum logic [2:0] {
    IDLE,
    REF_REQ,
    ZQ_REQ,
    SR_ENTER,
    SR_ACTIVE,
    SR_EXIT
  } chan_state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_REF,
    CMD_ZQ,
    CMD_SR
  } cmd_t;
endpackage

// File: rtl/ddr_maint_chan.sv
// One MIG channel's maintenance handshake: request/ack FSM for refresh, ZQ and self-refresh,
// with a per-state timeout and a calibration-loss abort.
module ddr_maint_chan
  import ddr_maint_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_calib_done,
  input  logic       i_start,
  input  logic [1:0] i_cmd,
  input  logic       i_sr_req,
  input  logic       i_ref_ack,
  input  logic       i_zq_ack,
  input  logic       i_sr_active,
  output logic       o_ref_req,
  output logic       o_zq_req,
  output logic       o_sr_req,
  output logic       o_idle,
  output logic       o_in_sr,
  output logic       o_sr_held,
  output logic       o_timeout,
  output logic       o_done
);

  chan_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ref_req_q, ref_req_d;
  logic                 zq_req_q, zq_req_d;
  logic                 sr_req_q, sr_req_d;
  logic                 timeout_q, timeout_d;
  logic                 done_q, done_d;
  logic                 tmo_hit;

  assign tmo_hit = (cnt_q == CNT_WIDTH'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_WIDTH'(1);
    ref_req_d = ref_req_q;
    zq_req_d  = zq_req_q;
    sr_req_d  = sr_req_q;
    timeout_d = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          unique case (cmd_t'(i_cmd))
            CMD_REF: begin state_d = REF_REQ;  ref_req_d = 1'b1; end
            CMD_ZQ:  begin state_d = ZQ_REQ;   zq_req_d  = 1'b1; end
            CMD_SR:  begin state_d = SR_ENTER; sr_req_d  = 1'b1; end
            default: state_d = IDLE;
          endcase
        end
      end
      REF_REQ: begin
        if (i_ref_ack) begin
          state_d = IDLE; ref_req_d = 1'b0; done_d = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE; ref_req_d = 1'b0; timeout_d = 1'b1;
        end
      end
      ZQ_REQ: begin
        if (i_zq_ack) begin
          state_d = IDLE; zq_req_d = 1'b0; done_d = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE; zq_req_d = 1'b0; timeout_d = 1'b1;
        end
      end
      SR_ENTER: begin
        if (i_sr_active) begin
          state_d = SR_ACTIVE;
        end else if (tmo_hit) begin
          state_d = IDLE; sr_req_d = 1'b0; timeout_d = 1'b1;
        end
      end
      SR_ACTIVE: begin
        if (!i_sr_req) begin
          state_d = SR_EXIT; sr_req_d = 1'b0;
        end
      end
      SR_EXIT: begin
        if (!i_sr_active) begin
          state_d = IDLE; done_d = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE; timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // Losing calibration aborts silently: no error and no completion credit.
    if (!i_calib_done && state_q != IDLE) begin
      state_d   = IDLE;
      cnt_d     = '0;
      ref_req_d = 1'b0;
      zq_req_d  = 1'b0;
      sr_req_d  = 1'b0;
      timeout_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ref_req_q <= 1'b0;
      zq_req_q  <= 1'b0;
      sr_req_q  <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_req_q <= ref_req_d;
      zq_req_q  <= zq_req_d;
      sr_req_q  <= sr_req_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign o_ref_req = ref_req_q;
  assign o_zq_req  = zq_req_q;
  assign o_sr_req  = sr_req_q;
  assign o_idle    = (state_q == IDLE);
  assign o_in_sr   = (state_q == SR_ENTER) || (state_q == SR_ACTIVE) || (state_q == SR_EXIT);
  assign o_sr_held = (state_q == SR_ACTIVE);
  assign o_timeout = timeout_q;
  assign o_done    = done_q;

endmodule

// File: rtl/ddr_maint_seq.sv
// Lockstep maintenance sequencer for 1..4 MIG controllers: refresh/ZQ timers, pending
// command flags, dispatch to all channels at once, completion counting and error flags.
module ddr_maint_seq
  import ddr_maint_pkg::*;
#(
  parameter int CHAN_TOTAL  = 1,
  parameter int CNT_WIDTH   = 16,
  parameter int REF_PERIOD  = 780,
  parameter int ZQ_PERIOD   = 128,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [CHAN_TOTAL-1:0] i_calib_done,
  input  logic                  i_ref_en,
  input  logic                  i_zq_en,
  input  logic                  i_sw_ref_req,
  input  logic                  i_sw_zq_req,
  input  logic                  i_sr_req,
  input  logic                  i_err_clr,
  output logic [CHAN_TOTAL-1:0] o_app_ref_req,
  input  logic [CHAN_TOTAL-1:0] i_app_ref_ack,
  output logic [CHAN_TOTAL-1:0] o_app_zq_req,
  input  logic [CHAN_TOTAL-1:0] i_app_zq_ack,
  output logic [CHAN_TOTAL-1:0] o_app_sr_req,
  input  logic [CHAN_TOTAL-1:0] i_app_sr_active,
  output logic                  o_busy,
  output logic                  o_sr_active,
  output logic                  o_err_timeout,
  output logic [CHAN_TOTAL-1:0] o_err_chan,
  output logic [31:0]           o_ref_cnt
);

  localparam logic [CNT_WIDTH-1:0] REF_LAST = CNT_WIDTH'(REF_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] ZQ_LAST  = CNT_WIDTH'(ZQ_PERIOD - 1);

  logic [CHAN_TOTAL-1:0] idle, in_sr, sr_held, tmo, done;
  logic [CHAN_TOTAL-1:0] ok_q, ok_d, err_chan_q, err_chan_d;
  logic [CNT_WIDTH-1:0]  tmr_q, tmr_d, zq_div_q, zq_div_d;
  logic [31:0]           ref_cnt_q, ref_cnt_d;
  logic                  ref_pend_q, ref_pend_d, ref_per_q, ref_per_d, zq_pend_q, zq_pend_d;
  logic                  infl_per_q, infl_per_d;
  cmd_t                  infl_q, infl_d, disp_cmd;
  logic                  disp, ready, all_idle, tmr_run, tmr_wrap;

  assign ready    = &i_calib_done;
  assign all_idle = &idle;
  assign tmr_run  = ready && i_ref_en && !(|in_sr);
  assign tmr_wrap = tmr_run && (tmr_q == REF_LAST);

  always_comb begin
    tmr_d      = tmr_q;
    zq_div_d   = zq_div_q;
    ref_pend_d = ref_pend_q;
    ref_per_d  = ref_per_q;
    zq_pend_d  = zq_pend_q;
    infl_d     = infl_q;
    infl_per_d = infl_per_q;
    ok_d       = ok_q | done;
    ref_cnt_d  = ref_cnt_q;
    err_chan_d = (i_err_clr ? '0 : err_chan_q) | tmo;
    disp_cmd   = CMD_NONE;
    disp       = 1'b0;
    if (tmr_run) tmr_d = tmr_wrap ? '0 : tmr_q + CNT_WIDTH'(1);
    if (tmr_wrap) begin
      ref_pend_d = 1'b1;
      ref_per_d  = 1'b1;
    end
    if (i_sw_ref_req) ref_pend_d = 1'b1;
    if (i_sw_zq_req)  zq_pend_d  = 1'b1;
    // A command only counts once every channel is back in IDLE having completed it normally.
    if (all_idle && infl_q != CMD_NONE) begin
      infl_d = CMD_NONE;
      if (&ok_d) begin
        if (infl_q == CMD_REF) begin
          ref_cnt_d = ref_cnt_q + 32'd1;
          if (infl_per_q) begin
            if (zq_div_q == ZQ_LAST) begin
              zq_div_d = '0;
              if (i_zq_en) zq_pend_d = 1'b1;
            end else begin
              zq_div_d = zq_div_q + CNT_WIDTH'(1);
            end
          end
        end else if (infl_q == CMD_SR) begin
          zq_pend_d = 1'b1;
        end
      end
    end
    if (ready && all_idle) begin
      if (ref_pend_q) begin
        disp_cmd   = CMD_REF;
        ref_pend_d = 1'b0;
        ref_per_d  = 1'b0;
        infl_per_d = ref_per_q;
      end else if (zq_pend_q) begin
        disp_cmd  = CMD_ZQ;
        zq_pend_d = 1'b0;
      end else if (i_sr_req) begin
        disp_cmd = CMD_SR;
      end
      if (disp_cmd != CMD_NONE) begin
        disp   = 1'b1;
        infl_d = disp_cmd;
        ok_d   = '0;
      end
    end
    if (|in_sr) begin
      ref_pend_d = 1'b0;
      ref_per_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      tmr_q      <= '0;
      zq_div_q   <= '0;
      ref_pend_q <= 1'b0;
      ref_per_q  <= 1'b0;
      zq_pend_q  <= 1'b0;
      infl_q     <= CMD_NONE;
      infl_per_q <= 1'b0;
      ok_q       <= '0;
      ref_cnt_q  <= '0;
      err_chan_q <= '0;
    end else begin
      tmr_q      <= tmr_d;
      zq_div_q   <= zq_div_d;
      ref_pend_q <= ref_pend_d;
      ref_per_q  <= ref_per_d;
      zq_pend_q  <= zq_pend_d;
      infl_q     <= infl_d;
      infl_per_q <= infl_per_d;
      ok_q       <= ok_d;
      ref_cnt_q  <= ref_cnt_d;
      err_chan_q <= err_chan_d;
    end
  end

  for (genvar g = 0; g < CHAN_TOTAL; g++) begin : g_chan
    ddr_maint_chan #(
      .CNT_WIDTH  (CNT_WIDTH),
      .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_chan (
      .clk         (i_clk),
      .rst_n       (i_nrst),
      .i_calib_done(i_calib_done[g]),
      .i_start     (disp),
      .i_cmd       (disp_cmd),
      .i_sr_req    (i_sr_req),
      .i_ref_ack   (i_app_ref_ack[g]),
      .i_zq_ack    (i_app_zq_ack[g]),
      .i_sr_active (i_app_sr_active[g]),
      .o_ref_req   (o_app_ref_req[g]),
      .o_zq_req    (o_app_zq_req[g]),
      .o_sr_req    (o_app_sr_req[g]),
      .o_idle      (idle[g]),
      .o_in_sr     (in_sr[g]),
      .o_sr_held   (sr_held[g]),
      .o_timeout   (tmo[g]),
      .o_done      (done[g])
    );
  end

  assign o_busy        = !all_idle || ref_pend_q || zq_pend_q;
  assign o_sr_active   = &sr_held;
  assign o_err_timeout = |tmo;
  assign o_err_chan    = err_chan_q;
  assign o_ref_cnt     = ref_cnt_q;

endmodule

// File: tb/tb_ddr_maint_seq.sv
// Directed bench for ddr_maint_seq with two channels: a cycle table for software commands,
// then hand sequences for periodic refresh/ZQ, merge, self-refresh, timeout and abort cases.
module tb_ddr_maint_seq;

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  calib, ref_ack, zq_ack, sr_active;
  logic        ref_en, zq_en, sw_ref, sw_zq, sr_req, err_clr;
  logic [1:0]  ref_req_o, zq_req_o, sr_req_o, err_chan_o;
  logic        busy_o, sr_active_o, err_tmo_o;
  logic [31:0] ref_cnt_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int sw_ref; int sw_zq; int ref_ack; int zq_ack;
    int e_ref;  int e_zq;  int e_busy;  int e_cnt;
  } vec_t;
  vec_t tbl[13];

  ddr_maint_seq #(
    .CHAN_TOTAL(2), .CNT_WIDTH(16), .REF_PERIOD(32), .ZQ_PERIOD(2), .ACK_TIMEOUT(15)
  ) dut (
    .i_clk(clk), .i_nrst(nrst), .i_calib_done(calib), .i_ref_en(ref_en), .i_zq_en(zq_en),
    .i_sw_ref_req(sw_ref), .i_sw_zq_req(sw_zq), .i_sr_req(sr_req), .i_err_clr(err_clr),
    .o_app_ref_req(ref_req_o), .i_app_ref_ack(ref_ack), .o_app_zq_req(zq_req_o),
    .i_app_zq_ack(zq_ack), .o_app_sr_req(sr_req_o), .i_app_sr_active(sr_active),
    .o_busy(busy_o), .o_sr_active(sr_active_o), .o_err_timeout(err_tmo_o),
    .o_err_chan(err_chan_o), .o_ref_cnt(ref_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    calib = 2'b11; ref_ack = '0; zq_ack = '0; sr_active = '0;
    ref_en = 0; zq_en = 0; sw_ref = 0; sw_zq = 0; sr_req = 0; err_clr = 0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic wait_ref(input int bound);
    int w = 0;
    while (ref_req_o != 2'b11 && w < bound) begin
      tick();
      w++;
    end
  endtask

  task automatic ack_ref_after3();
    tick();
    tick();
    ref_ack = 2'b11;
    tick();
    ref_ack = 2'b00;
  endtask

  initial begin
    int last, rises, bad, n, pulses, w;
    logic prev;
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 3, 0, 1, 0};
    tbl[2]  = '{0, 0, 1, 0, 2, 0, 1, 0};
    tbl[3]  = '{0, 0, 2, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[5]  = '{0, 1, 3, 0, 0, 0, 1, 1};
    tbl[6]  = '{0, 0, 3, 0, 0, 3, 1, 1};
    tbl[7]  = '{0, 0, 0, 3, 0, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 3, 0, 1, 1};
    tbl[10] = '{0, 0, 3, 3, 0, 0, 1, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 3, 1, 2};
    tbl[12] = '{0, 0, 0, 3, 0, 0, 0, 2};

    do_reset();
    chk("reset_outputs", {ref_req_o, zq_req_o, sr_req_o, busy_o, sr_active_o, err_tmo_o, err_chan_o},
        '0);
    chk("reset_cnt", ref_cnt_o, 0);

    // Software command table, timers disabled.
    for (int i = 0; i < 13; i++) begin
      sw_ref  = (tbl[i].sw_ref != 0);
      sw_zq   = (tbl[i].sw_zq != 0);
      ref_ack = 2'(tbl[i].ref_ack);
      zq_ack  = 2'(tbl[i].zq_ack);
      tick();
      chk($sformatf("tbl%0d_ref", i), ref_req_o, tbl[i].e_ref);
      chk($sformatf("tbl%0d_zq", i), zq_req_o, tbl[i].e_zq);
      chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
      chk($sformatf("tbl%0d_cnt", i), ref_cnt_o, tbl[i].e_cnt);
    end
    sw_ref = 0; sw_zq = 0; ref_ack = '0; zq_ack = '0;

    // Periodic refresh every 32 cycles, acked 3 cycles after request.
    do_reset();
    ref_en = 1;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ref(100);
      chk("t1_req", ref_req_o, 2'b11);
      if (k > 0) chk("t1_period", cyc - last, 32);
      last = cyc;
      ack_ref_after3();
      chk("t1_drop", ref_req_o, 2'b00);
      tick();
      chk("t1_cnt", ref_cnt_o, k + 1);
    end

    // Periodic ZQ after second refresh, staggered acks.
    do_reset();
    ref_en = 1; zq_en = 1;
    for (int k = 0; k < 2; k++) begin
      wait_ref(100);
      ack_ref_after3();
    end
    w = 0;
    while (zq_req_o == 2'b00 && w < 20) begin
      tick();
      w++;
    end
    chk("t2_zq_both", zq_req_o, 2'b11);
    for (int j = 1; j <= 9; j++) begin
      zq_ack = (j == 2) ? 2'b01 : (j == 9) ? 2'b10 : 2'b00;
      tick();
      zq_ack = 2'b00;
      if (j == 2) chk("t2_ch0_drop", zq_req_o, 2'b10);
      if (j < 9) chk($sformatf("t2_busy%0d", j), busy_o, 1);
    end
    chk("t2_busy_low", busy_o, 0);
    chk("t2_zq_low", zq_req_o, 2'b00);
    chk("t2_cnt", ref_cnt_o, 2);
    chk("t2_noerr", err_chan_o, 2'b00);

    // Software refresh on the timer-wrap cycle merges into one command.
    do_reset();
    ref_en = 1;
    repeat (31) tick();
    sw_ref = 1;
    tick();
    sw_ref = 0;
    rises = 0;
    prev = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (ref_req_o == 2'b11 && !prev) rises++;
      prev = (ref_req_o == 2'b11);
      ref_ack = prev ? 2'b11 : 2'b00;
    end
    ref_ack = '0;
    chk("t3_rises", rises, 1);
    chk("t3_cnt", ref_cnt_o, 1);

    // Self-refresh entry, hold, exit, followed by one ZQ.
    do_reset();
    ref_en = 1;
    sr_req = 1;
    tick();
    chk("t4_sr_req", sr_req_o, 2'b11);
    repeat (4) tick();
    sr_active = 2'b11;
    tick();
    chk("t4_sr_active", sr_active_o, 1);
    bad = 0;
    for (int j = 0; j < 200; j++) begin
      tick();
      if (ref_req_o != 2'b00 || sr_req_o != 2'b11) bad++;
    end
    chk("t4_hold", bad, 0);
    sr_req = 0;
    tick();
    chk("t4_sr_drop", sr_req_o, 2'b00);
    chk("t4_sr_active_low", sr_active_o, 0);
    tick();
    tick();
    sr_active = 2'b00;
    tick();
    w = 0;
    while (zq_req_o == 2'b00 && w < 10) begin
      tick();
      w++;
    end
    chk("t4_zq", zq_req_o, 2'b11);
    chk("t4_noref", ref_req_o, 2'b00);
    zq_ack = 2'b11;
    tick();
    zq_ack = 2'b00;
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (zq_req_o != 2'b00) bad++;
    end
    chk("t4_one_zq", bad, 0);

    // Channel 1 never acks: timeout after 15 cycles.
    do_reset();
    sw_ref = 1;
    tick();
    sw_ref = 0;
    tick();
    n = 0;
    pulses = 0;
    while (ref_req_o[1] && n < 40) begin
      n++;
      ref_ack = (n == 2) ? 2'b01 : 2'b00;
      tick();
      if (err_tmo_o) pulses++;
    end
    ref_ack = '0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (err_tmo_o) pulses++;
    end
    chk("t5_req_cycles", n, 15);
    chk("t5_pulses", pulses, 1);
    chk("t5_err_chan", err_chan_o, 2'b10);
    chk("t5_cnt", ref_cnt_o, 0);
    chk("t5_busy", busy_o, 0);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("t5_clr", err_chan_o, 2'b00);

    // Calibration loss mid-refresh, then reset during self-refresh.
    do_reset();
    sw_ref = 1;
    tick();
    sw_ref = 0;
    tick();
    chk("t6_req", ref_req_o, 2'b11);
    calib = 2'b10;
    tick();
    chk("t6_ch0_drop", ref_req_o, 2'b10);
    pulses = 0;
    ref_ack = 2'b10;
    tick();
    ref_ack = 2'b00;
    if (err_tmo_o) pulses++;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (err_tmo_o) pulses++;
    end
    chk("t6_no_pulse", pulses, 0);
    chk("t6_no_err", err_chan_o, 2'b00);
    chk("t6_no_cnt", ref_cnt_o, 0);
    calib = 2'b11;
    sr_req = 1;
    tick();
    tick();
    sr_active = 2'b11;
    tick();
    chk("t6_sr_pre", sr_active_o, 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("t6_async_rst", {ref_req_o, zq_req_o, sr_req_o, busy_o, sr_active_o, err_tmo_o, err_chan_o},
        '0);
    chk("t6_rst_cnt", ref_cnt_o, 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
